// File: rtl/button_reader_if.sv
// Button bus: raw pins in, debounced level and single-cycle event pulses out.
interface button_reader_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_long;

  // Board/testbench side: drives the pins, consumes the events
  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_long
  );

  // Reader side: samples the pins, produces the events
  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_long
  );
endinterface

// File: rtl/button_reader.sv
// Push-button reader: per-channel 2-flop synchroniser, debounce FSM and
// long-press detector. Produces a clean level plus one-cycle press,
// release and long-press pulses, all registered in the clk_in domain.
module button_reader #(
  parameter int N_BTN             = 4,
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int LONG_PRESS_CYCLES = 10000000,
  parameter bit ACTIVE_LOW        = 1'b1
) (
  input logic            clk_in,
  input logic            rst_n,
  button_reader_if.slave btn
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DEB_ONE  = DW'(1);
  localparam logic [LW-1:0] LONG_MAX = LW'(LONG_PRESS_CYCLES);
  localparam logic [LW-1:0] LONG_PRE = LW'(LONG_PRESS_CYCLES - 1);
  localparam logic [LW-1:0] LONG_ONE = LW'(1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_PEND = 2'd1,
    HELD       = 2'd2,
    REL_PEND   = 2'd3
  } state_t;

  // Normalise polarity so that 1 always means pressed
  logic [N_BTN-1:0] p;
  assign p = btn.btn_raw ^ {N_BTN{ACTIVE_LOW}};

  logic [N_BTN-1:0] s1_q;
  logic [N_BTN-1:0] s2_q;
  state_t           state_q [N_BTN];
  logic [DW-1:0]    dcnt_q  [N_BTN];
  logic [LW-1:0]    lcnt_q  [N_BTN];
  logic [N_BTN-1:0] level_q;
  logic [N_BTN-1:0] press_q;
  logic [N_BTN-1:0] release_q;
  logic [N_BTN-1:0] long_q;

  // Two-flop synchroniser; reset forces the released value so a button held
  // through reset must still pass a full debounce before being reported
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= p;
      s2_q <= s1_q;
    end
  end

  // Per-channel debounce FSM and long-press counter with registered outputs
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= IDLE;
        dcnt_q[i]  <= '0;
        lcnt_q[i]  <= '0;
      end
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
    end else begin
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        case (state_q[i])
          IDLE: begin
            if (s2_q[i]) begin
              state_q[i] <= PRESS_PEND;
              dcnt_q[i]  <= DEB_ONE;
            end
          end
          PRESS_PEND: begin
            if (!s2_q[i]) begin
              state_q[i] <= IDLE;
              dcnt_q[i]  <= '0;
            end else if (dcnt_q[i] == DEB_MAX) begin
              state_q[i] <= HELD;
              dcnt_q[i]  <= '0;
              level_q[i] <= 1'b1;
              press_q[i] <= 1'b1;
            end else begin
              dcnt_q[i]  <= dcnt_q[i] + DEB_ONE;
            end
          end
          HELD: begin
            if (!s2_q[i]) begin
              state_q[i] <= REL_PEND;
              dcnt_q[i]  <= DEB_ONE;
            end
          end
          REL_PEND: begin
            if (s2_q[i]) begin
              state_q[i] <= HELD;
              dcnt_q[i]  <= '0;
            end else if (dcnt_q[i] == DEB_MAX) begin
              state_q[i]   <= IDLE;
              dcnt_q[i]    <= '0;
              level_q[i]   <= 1'b0;
              release_q[i] <= 1'b1;
            end else begin
              dcnt_q[i]    <= dcnt_q[i] + DEB_ONE;
            end
          end
          default: begin
            state_q[i] <= IDLE;
            dcnt_q[i]  <= '0;
          end
        endcase

        // Long-press timing runs off the registered level, so pending-release
        // cycles still count; saturation guarantees a single pulse per press
        if (!level_q[i]) begin
          lcnt_q[i] <= '0;
        end else if (lcnt_q[i] != LONG_MAX) begin
          lcnt_q[i] <= lcnt_q[i] + LONG_ONE;
        end
        long_q[i] <= level_q[i] && (lcnt_q[i] == LONG_PRE);
      end
    end
  end

  assign btn.btn_level   = level_q;
  assign btn.btn_press   = press_q;
  assign btn.btn_release = release_q;
  assign btn.btn_long    = long_q;

endmodule

// File: doc/button_reader.md
# button_reader

Input-side companion to the LED blinker: samples the board push-buttons, synchronises and debounces them, and presents clean levels plus single-cycle press, release and long-press events to the rest of the design. One independent channel per button, all in the `clk_in` domain. Downstream logic, such as LED pattern selection, consumes events without handling metastability or contact bounce.

## Interface
- `N_BTN`, default 4: number of button channels.
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a level change. Must be ≥ 1.
- `LONG_PRESS_CYCLES`, default 10000000: cycles of held debounced press before the long event. Must be ≥ 1.
- `ACTIVE_LOW`, default 1: 1 means a raw pin low means pressed; 0 means a raw pin high means pressed.
- `clk_in` input, 1 bit: the single clock; all logic is rising-edge.
- `rst_n` input, 1 bit: reset, synchronous and active-low.
- `btn_raw` input, N_BTN bits: asynchronous raw button pins.
- `btn_level` output, N_BTN bits: debounced state, 1 = pressed.
- `btn_press` output, N_BTN bits: one-cycle pulse on an accepted press.
- `btn_release` output, N_BTN bits: one-cycle pulse on an accepted release.
- `btn_long` output, N_BTN bits: one-cycle pulse when a press has been held LONG_PRESS_CYCLES cycles.

## Operation
- Per channel, the raw pin is XORed with ACTIVE_LOW to give `p` (1 = pressed). `p` then passes through a 2-flop synchroniser, `s1` followed by `s2`.
- Per-channel FSM states:
  - IDLE: stable released, `btn_level`=0.
  - PRESS_PEND: candidate press.
  - HELD: stable pressed, `btn_level`=1.
  - REL_PEND: candidate release.
- Debounce counter `dcnt`, width $clog2(DEBOUNCE_CYCLES+1):
  - IDLE with `s2`=1: go to PRESS_PEND, `dcnt`=1.
  - PRESS_PEND with `s2`=1 and `dcnt`<DEBOUNCE_CYCLES: `dcnt`++.
  - PRESS_PEND with `s2`=1 and `dcnt`==DEBOUNCE_CYCLES: go to HELD, `dcnt`=0, `btn_press` pulses.
  - PRESS_PEND with `s2`=0: return to IDLE, `dcnt`=0, no event.
  - HELD and REL_PEND are the mirror image with `s2`=0. Completion goes to IDLE and pulses `btn_release`. A bounce back returns to HELD.
- `btn_level` is a registered output: 1 in HELD and REL_PEND, 0 in IDLE and PRESS_PEND.
- Long-press counter `lcnt`, width $clog2(LONG_PRESS_CYCLES+1):
  - Cleared on every cycle where `btn_level`=0.
  - Increments each cycle `btn_level`=1, saturating at LONG_PRESS_CYCLES.
  - `btn_long` pulses exactly once per press, on the cycle `lcnt` goes from LONG_PRESS_CYCLES-1 to LONG_PRESS_CYCLES. It never repeats.
  - REL_PEND cycles count toward `lcnt`, because the level is still 1.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.
- `btn_press` and `btn_release` are never both high on one channel in the same cycle.

## Timing
- Reset, on `rst_n`=0 at a rising edge:
  - All channels go to IDLE; `dcnt`=`lcnt`=0.
  - `s1` and `s2` are forced to 0, the released value, so a button held through reset produces no spurious event before debounce.
  - All outputs are 0 in the cycle after the reset edge.
- Reset mid-operation (pending or held) abandons the state silently: no release pulse is generated.
- Press latency: `p` goes to 1 and stays there, first sampled into `s1` at edge E. `s2`=1 after E+1, and PRESS_PEND is entered at E+2. `btn_level` and `btn_press` go high after edge E+2+DEBOUNCE_CYCLES, which is DEBOUNCE_CYCLES+2 edges after first sampling.
- Release latency is identical: DEBOUNCE_CYCLES+2 edges.
- `btn_long` goes high LONG_PRESS_CYCLES cycles after `btn_press`, provided no accepted release occurs first.
- A bounce shorter than DEBOUNCE_CYCLES consecutive stable cycles produces no output change. Each reversal restarts the count from the stable state.
- Every event output is high for exactly one `clk_in` cycle.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16, ACTIVE_LOW=1, N_BTN=4.
- Reset with `btn_raw`=4'b1111, release `rst_n`, run 20 cycles -> all outputs stay 0.
- Drive `btn_raw[0]`=0 from edge E and hold -> `btn_level[0]`=1 and a single-cycle `btn_press[0]` after edge E+6. `btn_long[0]` pulses once, 16 cycles after `btn_press[0]`. No repeat over a further 50 cycles.
- Drive `btn_raw[1]` low for 3 cycles, high for 2, low for 3, then high -> no change on any output.
- Press `btn_raw[2]` and hold 10 cycles, then release -> `btn_release[2]` pulses 6 edges after the release edge. No `btn_long[2]`. `lcnt` is 0 afterwards.
- Press `btn_raw[0]` and `btn_raw[3]` on the same edge -> `btn_press[0]` and `btn_press[3]` are high in the same cycle.
- Assert `rst_n`=0 while `btn_level[1]`=1 -> outputs are 0 the next cycle with no `btn_release[1]` pulse. With the button still held after reset, a fresh `btn_press[1]` arrives 6 edges after reset deassertion.
